ccff_chain_programmer: RTL and testbench

//   Drives the fabric configuration chains (ccff_head, prog_clock, config_enable, CFG_DONE).

---
 rtl/ccff_chain_programmer.sv | 180 ++++++++++++++++++
 tb/tb_ccff_chain_programmer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_programmer.sv
// Streams bitstream columns into the fabric configuration chains, one prog_clock
// pulse per accepted column, and flags completion once every chain is full.
module ccff_chain_programmer #(
  parameter int NUM_CHAINS = 10,
  parameter int CHAIN_LEN  = 1024,
  parameter int PROG_DIV   = 2,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_CHAINS-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  prog_clock,
  output logic                  config_enable,
  output logic                  cfg_done,
  output logic                  busy,
  output logic                  aborted,
  output logic [CNT_W-1:0]      bit_cnt
);

  localparam int               DIV_W    = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PROG_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [NUM_CHAINS-1:0]   ccff_head_q, ccff_head_d;
  logic                    s_ready_q, s_ready_d;
  logic                    prog_clock_q, prog_clock_d;
  logic                    config_enable_q, config_enable_d;
  logic                    cfg_done_q, cfg_done_d;
  logic                    busy_q, busy_d;
  logic                    aborted_q, aborted_d;
  logic [CNT_W-1:0]        bit_cnt_inc;

  // Saturating increment so the column count can never wrap past a full load.
  assign bit_cnt_inc = (bit_cnt_q == CNT_FULL) ? bit_cnt_q : bit_cnt_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    div_d           = div_q;
    bit_cnt_d       = bit_cnt_q;
    ccff_head_d     = ccff_head_q;
    s_ready_d       = s_ready_q;
    prog_clock_d    = prog_clock_q;
    config_enable_d = config_enable_q;
    cfg_done_d      = cfg_done_q;
    busy_d          = busy_q;
    aborted_d       = aborted_q;

    if (abort && (state_q != ST_IDLE)) begin
      // Abort outranks everything, including a handshake in flight this cycle.
      state_d         = ST_IDLE;
      div_d           = '0;
      s_ready_d       = 1'b0;
      prog_clock_d    = 1'b0;
      config_enable_d = 1'b0;
      cfg_done_d      = 1'b0;
      busy_d          = 1'b0;
      aborted_d       = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            state_d         = ST_SETUP;
            bit_cnt_d       = '0;
            cfg_done_d      = 1'b0;
            aborted_d       = 1'b0;
            config_enable_d = 1'b1;
            prog_clock_d    = 1'b0;
            busy_d          = 1'b1;
          end
        end
        ST_SETUP: begin
          state_d   = ST_LOAD;
          s_ready_d = 1'b1;
        end
        ST_LOAD: begin
          if (s_valid && s_ready_q) begin
            ccff_head_d = s_data;
            s_ready_d   = 1'b0;
            div_d       = '0;
            state_d     = ST_LOW;
          end
        end
        ST_LOW: begin
          if (div_q == DIV_LAST) begin
            div_d        = '0;
            prog_clock_d = 1'b1;
            state_d      = ST_HIGH;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (div_q == DIV_LAST) begin
            div_d        = '0;
            prog_clock_d = 1'b0;
            bit_cnt_d    = bit_cnt_inc;
            if (bit_cnt_inc == CNT_FULL) begin
              state_d         = ST_DONE;
              config_enable_d = 1'b0;
              cfg_done_d      = 1'b1;
              busy_d          = 1'b0;
            end else begin
              state_d   = ST_LOAD;
              s_ready_d = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: begin
          state_d         = ST_IDLE;
          div_d           = '0;
          s_ready_d       = 1'b0;
          prog_clock_d    = 1'b0;
          config_enable_d = 1'b0;
          busy_d          = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q         <= ST_IDLE;
      div_q           <= '0;
      bit_cnt_q       <= '0;
      ccff_head_q     <= '0;
      s_ready_q       <= 1'b0;
      prog_clock_q    <= 1'b0;
      config_enable_q <= 1'b0;
      cfg_done_q      <= 1'b0;
      busy_q          <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      bit_cnt_q       <= bit_cnt_d;
      ccff_head_q     <= ccff_head_d;
      s_ready_q       <= s_ready_d;
      prog_clock_q    <= prog_clock_d;
      config_enable_q <= config_enable_d;
      cfg_done_q      <= cfg_done_d;
      busy_q          <= busy_d;
      aborted_q       <= aborted_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign ccff_head     = ccff_head_q;
  assign prog_clock    = prog_clock_q;
  assign config_enable = config_enable_q;
  assign cfg_done      = cfg_done_q;
  assign busy          = busy_q;
  assign aborted       = aborted_q;
  assign bit_cnt       = bit_cnt_q;

  // Structural invariants: the stream is only open in LOAD, the count never overshoots.
  a_ready_only_in_load: assert property (@(posedge clk) disable iff (!global_reset_n)
    s_ready_q |-> (state_q == ST_LOAD));
  a_cnt_bounded: assert property (@(posedge clk) disable iff (!global_reset_n)
    bit_cnt_q <= CNT_FULL);

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Directed bench: full loads, stalls, abort, start handling and async reset mid-pulse.
module tb_ccff_chain_programmer;

  localparam int NUM_CHAINS = 2;
  localparam int CHAIN_LEN  = 4;
  localparam int PROG_DIV   = 1;
  localparam int CNT_W      = $clog2(CHAIN_LEN + 1);

  logic                  clk;
  logic                  global_reset_n;
  logic                  start;
  logic                  abort;
  logic [NUM_CHAINS-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [NUM_CHAINS-1:0] ccff_head;
  logic                  prog_clock;
  logic                  config_enable;
  logic                  cfg_done;
  logic                  busy;
  logic                  aborted;
  logic [CNT_W-1:0]      bit_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int rise_cnt    = 0;
  int col_idx     = 0;
  int base;
  bit found;
  logic [NUM_CHAINS-1:0] heads [0:63];
  logic [NUM_CHAINS-1:0] col_tab [0:3];

  ccff_chain_programmer #(
    .NUM_CHAINS(NUM_CHAINS),
    .CHAIN_LEN (CHAIN_LEN),
    .PROG_DIV  (PROG_DIV)
  ) dut (
    .clk           (clk),
    .global_reset_n(global_reset_n),
    .start         (start),
    .abort         (abort),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .prog_clock    (prog_clock),
    .config_enable (config_enable),
    .cfg_done      (cfg_done),
    .busy          (busy),
    .aborted       (aborted),
    .bit_cnt       (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain data is captured at every programming-clock rise, as the fabric would see it.
  always @(posedge prog_clock) begin
    if (rise_cnt < 64) heads[rise_cnt] = ccff_head;
    rise_cnt = rise_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors = vectors + 1;
    if (observed !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs at the falling edge; the column index advances when a handshake will occur.
  task automatic applyStimulus(input logic st, input logic ab, input logic vld);
    start   = st;
    abort   = ab;
    s_valid = vld;
    s_data  = (col_idx < 4) ? col_tab[col_idx] : '0;
    if (vld && s_ready && !ab) col_idx = col_idx + 1;
  endtask

  task automatic waitDone(input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cfg_done) begin
        hit = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput({tag, "_reach_done"}, 32'(hit), 32'd1);
  endtask

  task automatic checkLoad(input string tag, input int b);
    checkOutput({tag, "_rises"}, 32'(rise_cnt - b), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("%s_head%0d", tag, k), 32'(heads[b + k]), 32'(col_tab[k]));
    checkOutput({tag, "_bit_cnt"}, 32'(bit_cnt), 32'd4);
    checkOutput({tag, "_cfg_en"}, 32'(config_enable), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic beginLoad();
    col_idx = 0;
    base    = rise_cnt;
    applyStimulus(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    col_tab[0] = 2'b01;
    col_tab[1] = 2'b10;
    col_tab[2] = 2'b11;
    col_tab[3] = 2'b00;
    global_reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({ccff_head, prog_clock, config_enable, cfg_done, busy, aborted, s_ready, bit_cnt}), 32'd0);
    global_reset_n = 1'b1;
    base = rise_cnt;
    repeat (10) @(negedge clk);
    checkOutput("idle_outputs",
                32'({ccff_head, prog_clock, config_enable, cfg_done, busy, aborted, s_ready, bit_cnt}), 32'd0);
    checkOutput("idle_no_rise", 32'(rise_cnt - base), 32'd0);

    // 2: full load with s_valid held high; done lands 13 cycles after start
    $display("[TB] full load");
    beginLoad();
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1)  checkOutput("setup_cfg_en_ready", 32'({config_enable, busy, s_ready}), 32'b110);
      if (i == 2)  checkOutput("load_ready", 32'(s_ready), 32'd1);
      if (i == 3)  checkOutput("low_head", 32'({ccff_head, prog_clock}), 32'b010);
      if (i == 4)  checkOutput("high_pulse", 32'(prog_clock), 32'd1);
      if (i == 5)  checkOutput("col1_count", 32'(bit_cnt), 32'd1);
      if (i == 13) checkOutput("cycle12_not_done", 32'({cfg_done, config_enable}), 32'b01);
      if (i == 14) checkOutput("cycle13_done", 32'({cfg_done, config_enable, prog_clock, s_ready}), 32'b1000);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkLoad("full", base);

    // 3: stall for 5 cycles after the second column
    $display("[TB] stalled load");
    beginLoad();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, col_idx < 2);
      if (bit_cnt == 2 && s_ready) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("stall_reached", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_clk_cnt", i), 32'({prog_clock, bit_cnt}), 32'({1'b0, 3'd2}));
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone("stall");
    checkLoad("stall", base);

    // 4: abort during the high phase of column 3
    $display("[TB] abort");
    beginLoad();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (prog_clock && bit_cnt == 2) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("abort_high_found", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("abort_outputs",
                32'({prog_clock, config_enable, cfg_done, busy, s_ready, aborted}), 32'b000001);
    checkOutput("abort_bit_cnt", 32'(bit_cnt), 32'd2);
    checkOutput("abort_rises", 32'(rise_cnt - base), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_stays_idle", 32'({busy, aborted, bit_cnt}), 32'({1'b0, 1'b1, 3'd2}));
    beginLoad();
    @(negedge clk);
    checkOutput("restart_clears", 32'({aborted, config_enable, bit_cnt}), 32'({1'b0, 1'b1, 3'd0}));
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone("reload");
    checkLoad("reload", base);

    // 5: start during LOAD ignored; start in DONE begins a fresh load
    $display("[TB] start handling");
    beginLoad();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_ready && bit_cnt == 1) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("load_start_found", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("load_start_ignored", 32'({busy, config_enable, s_ready, bit_cnt}), 32'({3'b110, 3'd1}));
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone("ignore");
    checkLoad("ignore", base);
    beginLoad();
    @(negedge clk);
    checkOutput("done_restart", 32'({cfg_done, config_enable, busy, bit_cnt}), 32'({3'b011, 3'd0}));
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone("again");
    checkLoad("again", base);

    // 6: asynchronous reset in the middle of a prog_clock pulse
    $display("[TB] async reset");
    beginLoad();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (prog_clock && bit_cnt == 1) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("rst_high_found", 32'(found), 32'd1);
    #2 global_reset_n = 1'b0;
    #1;
    checkOutput("rst_immediate",
                32'({prog_clock, config_enable, s_ready, busy, bit_cnt}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    global_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_release_idle",
                32'({prog_clock, config_enable, cfg_done, busy, s_ready, aborted}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
